// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and address types for the dual-write register file
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy flags and operand-ready lookup
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    al_a_i,
  input  logic             al_e_i,
  input  logic             wr3_en_i,
  input  logic [AW-1:0]    wr3_a_i,
  input  logic             wr4_en_i,
  input  logic [AW-1:0]    wr4_a_i,
  input  logic [AW-1:0]    rd1_a_i,
  input  logic [AW-1:0]    rd2_a_i,
  output logic [NREGS-1:0] busy_o,
  output logic             rdy1_o,
  output logic             rdy2_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             al_eff;

  // An allocation of the hardwired zero register would never be released, so drop it.
  assign al_eff = al_e_i && !((ZERO_REG != 0) && (al_a_i == AW'(ZERO_ADDR)));

  // Next busy state: writes release, a same-cycle allocate overrides the release.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (wr3_en_i && (wr3_a_i == AW'(r))) busy_d[r] = 1'b0;
      if (wr4_en_i && (wr4_a_i == AW'(r))) busy_d[r] = 1'b0;
      if (al_eff && (al_a_i == AW'(r)))    busy_d[r] = 1'b1;
    end
  end

  // Busy flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  // Ready when not pending or the producer's result is being bypassed right now.
  always_comb begin
    rdy1_o = ((ZERO_REG != 0) && (rd1_a_i == AW'(ZERO_ADDR))) || !busy_q[rd1_a_i] ||
             (wr3_en_i && (wr3_a_i == rd1_a_i)) || (wr4_en_i && (wr4_a_i == rd1_a_i));
    rdy2_o = ((ZERO_REG != 0) && (rd2_a_i == AW'(ZERO_ADDR))) || !busy_q[rd2_a_i] ||
             (wr3_en_i && (wr3_a_i == rd2_a_i)) || (wr4_en_i && (wr4_a_i == rd2_a_i));
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_dual_write.sv
// rtl/rf_dual_write.sv - two-read two-write register file with bypass and busy scoreboard
module rf_dual_write
  import rf_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  output logic [XLEN-1:0]  RD1,
  output logic [XLEN-1:0]  RD2,
  output logic             RDY1,
  output logic             RDY2,
  input  logic [AW-1:0]    A3,
  input  logic [AW-1:0]    A4,
  input  logic [XLEN-1:0]  WD3,
  input  logic [XLEN-1:0]  WD4,
  input  logic             WE3,
  input  logic             WE4,
  input  logic [AW-1:0]    AL_A,
  input  logic             AL_E,
  output logic [NREGS-1:0] BUSY
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            wr3_en;
  logic            wr4_en;
  logic            zero1;
  logic            zero2;

  // Writes to the hardwired zero register are squashed before they reach storage or scoreboard.
  assign wr3_en = WE3 && !((ZERO_REG != 0) && (A3 == AW'(ZERO_ADDR)));
  assign wr4_en = WE4 && !((ZERO_REG != 0) && (A4 == AW'(ZERO_ADDR)));
  assign zero1  = (ZERO_REG != 0) && (A1 == AW'(ZERO_ADDR));
  assign zero2  = (ZERO_REG != 0) && (A2 == AW'(ZERO_ADDR));

  // Write arbitration: port 4 is applied last so it wins a same-address collision.
  always_comb begin
    rf_d = rf_q;
    if (wr3_en) rf_d[A3] = WD3;
    if (wr4_en) rf_d[A4] = WD4;
  end

  // Storage array; reset clears every entry, including register 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rf_q <= '{default: '0};
    else          rf_q <= rf_d;
  end

  // Read ports with write-through bypass, port 4 taking priority over port 3.
  always_comb begin
    if (zero1)                        RD1 = '0;
    else if (wr4_en && (A4 == A1))    RD1 = WD4;
    else if (wr3_en && (A3 == A1))    RD1 = WD3;
    else                              RD1 = rf_q[A1];
    if (zero2)                        RD2 = '0;
    else if (wr4_en && (A4 == A2))    RD2 = WD4;
    else if (wr3_en && (A3 == A2))    RD2 = WD3;
    else                              RD2 = rf_q[A2];
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .al_a_i   (AL_A),
    .al_e_i   (AL_E),
    .wr3_en_i (wr3_en),
    .wr3_a_i  (A3),
    .wr4_en_i (wr4_en),
    .wr4_a_i  (A4),
    .rd1_a_i  (A1),
    .rd2_a_i  (A2),
    .busy_o   (BUSY),
    .rdy1_o   (RDY1),
    .rdy2_o   (RDY2)
  );

endmodule

// File: tb/tb_rf_dual_write.sv
// tb/tb_rf_dual_write.sv - randomized reference-model bench for rf_dual_write
module tb_rf_dual_write;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   A1, A2, A3, A4, AL_A;
  logic [XLEN-1:0] WD3, WD4;
  logic            WE3, WE4, AL_E;

  // Index 0: ZERO_REG=1 instance, index 1: ZERO_REG=0 instance.
  logic [XLEN-1:0]  rd1 [2];
  logic [XLEN-1:0]  rd2 [2];
  logic             rdy1 [2];
  logic             rdy2 [2];
  logic [NREGS-1:0] busy [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] m_rf   [2][NREGS];
  logic            m_busy [2][NREGS];

  always #5 clk = ~clk;

  rf_dual_write #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .reset_n(reset_n),
    .A1(A1), .A2(A2), .RD1(rd1[0]), .RD2(rd2[0]), .RDY1(rdy1[0]), .RDY2(rdy2[0]),
    .A3(A3), .A4(A4), .WD3(WD3), .WD4(WD4), .WE3(WE3), .WE4(WE4),
    .AL_A(AL_A), .AL_E(AL_E), .BUSY(busy[0])
  );

  rf_dual_write #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(0)) u_dut_n (
    .clk(clk), .reset_n(reset_n),
    .A1(A1), .A2(A2), .RD1(rd1[1]), .RD2(rd2[1]), .RDY1(rdy1[1]), .RDY2(rdy2[1]),
    .A3(A3), .A4(A4), .WD3(WD3), .WD4(WD4), .WE3(WE3), .WE4(WE4),
    .AL_A(AL_A), .AL_E(AL_E), .BUSY(busy[1])
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit eff_wr(input int k, input logic we, input logic [AW-1:0] a);
    return we && !(k == 0 && a == 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int k, input logic [AW-1:0] a);
    if (k == 0 && a == 0)               return '0;
    if (eff_wr(k, WE4, A4) && A4 == a)  return WD4;
    if (eff_wr(k, WE3, A3) && A3 == a)  return WD3;
    return m_rf[k][a];
  endfunction

  function automatic logic exp_rdy(input int k, input logic [AW-1:0] a);
    return (k == 0 && a == 0) || !m_busy[k][a] ||
           (eff_wr(k, WE3, A3) && A3 == a) || (eff_wr(k, WE4, A4) && A4 == a);
  endfunction

  function automatic logic [NREGS-1:0] exp_busy(input int k);
    logic [NREGS-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[k][r];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NREGS; r++) begin
        m_rf[k][r]   = '0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  // Compare every combinational output of both instances with the model.
  task automatic check_model(input string tag);
    if (!reset_n) model_clear();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.i%0d.rd1", tag, k),  rd1[k], exp_rd(k, A1));
      chk($sformatf("%s.i%0d.rd2", tag, k),  rd2[k], exp_rd(k, A2));
      chk($sformatf("%s.i%0d.rdy1", tag, k), XLEN'(rdy1[k]), XLEN'(exp_rdy(k, A1)));
      chk($sformatf("%s.i%0d.rdy2", tag, k), XLEN'(rdy2[k]), XLEN'(exp_rdy(k, A2)));
      chk($sformatf("%s.i%0d.busy", tag, k), XLEN'(busy[k]), XLEN'(exp_busy(k)));
    end
  endtask

  // Clock edge: update the model from the inputs that were present, then return at negedge.
  task automatic advance();
    @(posedge clk);
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        if (eff_wr(k, WE3, A3)) begin m_rf[k][A3] = WD3; m_busy[k][A3] = 1'b0; end
        if (eff_wr(k, WE4, A4)) begin m_rf[k][A4] = WD4; m_busy[k][A4] = 1'b0; end
        if (AL_E && !(k == 0 && AL_A == 0)) m_busy[k][AL_A] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    WE3 = 0; WE4 = 0; AL_E = 0;
    A3 = '0; A4 = '0; AL_A = '0; WD3 = '0; WD4 = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    A1 = 4'd3; A2 = 4'd0;
    idle();
    model_clear();
    @(negedge clk);
    #1;
    chk("reset.rd1", rd1[1], '0);
    chk("reset.rdy1", XLEN'(rdy1[1]), XLEN'(1'b1));
    chk("reset.busy", XLEN'(busy[0]), '0);
    check_model("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Dual write to the same address: port 4 wins, also on the bypass path.
    WE3 = 1; WE4 = 1; A3 = 4'd5; A4 = 4'd5; WD3 = 64'h1111_1111; WD4 = 64'h2222_2222; A1 = 4'd5;
    #1;
    chk("dual.bypass", rd1[0], 64'h2222_2222);
    check_model("dual");
    advance();
    idle();
    #1;
    chk("dual.stored", rd1[0], 64'h2222_2222);

    // Register 0: hardwired in instance 0, writable in instance 1.
    WE3 = 1; A3 = 4'd0; WD3 = 64'hDEAD_BEEF; A1 = 4'd0;
    #1;
    check_model("zero.wr");
    advance();
    idle();
    #1;
    chk("zero.z.rd1", rd1[0], '0);
    chk("zero.n.rd1", rd1[1], 64'hDEAD_BEEF);
    chk("zero.z.busy0", XLEN'(busy[0][0]), '0);

    // Allocate register 0: ignored only when hardwired.
    AL_E = 1; AL_A = 4'd0;
    advance();
    idle();
    #1;
    chk("alloc0.z.busy0", XLEN'(busy[0][0]), '0);
    chk("alloc0.n.busy0", XLEN'(busy[1][0]), XLEN'(1'b1));
    check_model("alloc0");

    // Scoreboard lifecycle on register 7.
    AL_E = 1; AL_A = 4'd7; A1 = 4'd7;
    #1;
    chk("life.rdy_ignores_alloc", XLEN'(rdy1[0]), XLEN'(1'b1));
    advance();
    idle();
    #1;
    chk("life.busy7", XLEN'(busy[0][7]), XLEN'(1'b1));
    chk("life.rdy_pending", XLEN'(rdy1[0]), '0);
    WE3 = 1; A3 = 4'd7; WD3 = 64'h42;
    #1;
    chk("life.rdy_bypass", XLEN'(rdy1[0]), XLEN'(1'b1));
    chk("life.rd_bypass", rd1[0], 64'h42);
    advance();
    idle();
    #1;
    chk("life.released", XLEN'(busy[0][7]), '0);

    // Allocate and write collide on register 9: allocate wins, data still stored.
    AL_E = 1; AL_A = 4'd9; WE4 = 1; A4 = 4'd9; WD4 = 64'hCAFE_F00D_1234_5678;
    advance();
    idle();
    A1 = 4'd9; A2 = 4'd9;
    #1;
    chk("coll.busy9", XLEN'(busy[0][9]), XLEN'(1'b1));
    chk("coll.rd1", rd1[0], 64'hCAFE_F00D_1234_5678);
    check_model("coll");

    // Asynchronous reset mid-cycle while a write is presented; the write is lost.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    WE3 = 1; A3 = 4'd3; WD3 = 64'h77;
    #1;
    chk("areset.rd2", rd2[0], '0);
    chk("areset.rdy2", XLEN'(rdy2[0]), XLEN'(1'b1));
    chk("areset.busy", XLEN'(busy[0]), '0);
    model_clear();
    @(negedge clk);
    advance();
    reset_n = 1'b1;
    idle();
    A1 = 4'd3;
    #1;
    chk("areset.write_lost", rd1[0], '0);
    check_model("areset");

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      reset_n = ($urandom_range(0, 999) != 0);
      A1   = 4'($urandom_range(0, NREGS - 1));
      A2   = 4'($urandom_range(0, NREGS - 1));
      A3   = 4'($urandom_range(0, NREGS - 1));
      A4   = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom_range(0, NREGS - 1));
      AL_A = 4'($urandom_range(0, NREGS - 1));
      WD3  = {$urandom, $urandom};
      WD4  = {$urandom, $urandom};
      WE3  = 1'($urandom_range(0, 1));
      WE4  = 1'($urandom_range(0, 1));
      AL_E = ($urandom_range(0, 2) == 0);
      #1;
      check_model("rand");
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
